// File: rtl/spi_slave_rx.sv
// SPI target receiver: oversamples sclk/cs/mosi in the clk domain and delivers words on valid/ready.
// Optional per-frame word counter output enabled by `define SPI_SLAVE_RX_BYTE_COUNT_EN.
module spi_slave_rx #(
  parameter int unsigned DATA_W      = 8,
  parameter bit          SAMPLE_RISE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err,
`ifdef SPI_SLAVE_RX_BYTE_COUNT_EN
  output logic [7:0]        frame_words,
`endif
  output logic              busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic              sclk_meta_q, sclk_s_q, sclk_d_q;
  logic              cs_meta_q, cs_s_q;
  logic              mosi_meta_q, mosi_s_q;
  logic              strobe_c;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;
`ifdef SPI_SLAVE_RX_BYTE_COUNT_EN
  logic [7:0]        fw_q, fw_d;
`endif

  // Two-flop synchronisers plus a delayed sclk copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta_q <= 1'b0;
      sclk_s_q    <= 1'b0;
      sclk_d_q    <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_s_q      <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      sclk_meta_q <= sclk;
      sclk_s_q    <= sclk_meta_q;
      sclk_d_q    <= sclk_s_q;
      cs_meta_q   <= cs;
      cs_s_q      <= cs_meta_q;
      mosi_meta_q <= mosi;
      mosi_s_q    <= mosi_meta_q;
    end
  end

  assign strobe_c = SAMPLE_RISE ? (~sclk_d_q & sclk_s_q) : (sclk_d_q & ~sclk_s_q);

  // Next-state: framing, shifting and word delivery
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
`ifdef SPI_SLAVE_RX_BYTE_COUNT_EN
    fw_d        = fw_q;
`endif

    case (state_q)
      IDLE: begin
        shift_d = '0;
        cnt_d   = '0;
        if (!cs_s_q) begin
          state_d = SHIFT;
`ifdef SPI_SLAVE_RX_BYTE_COUNT_EN
          fw_d    = 8'd0;
`endif
        end
      end
      SHIFT: begin
        // cs release takes priority over a coincident sample
        if (cs_s_q) begin
          state_d     = IDLE;
          shift_d     = '0;
          cnt_d       = '0;
          frame_err_d = (cnt_q != '0);
        end else if (strobe_c) begin
          shift_d = {shift_q[DATA_W-2:0], mosi_s_q};
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d  = '0;
            done_d = 1'b1;
`ifdef SPI_SLAVE_RX_BYTE_COUNT_EN
            fw_d   = (fw_q == 8'hFF) ? fw_q : fw_q + 8'd1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A handshake in the completion cycle frees the slot for the new word
    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SPI_SLAVE_RX_BYTE_COUNT_EN
      fw_q        <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef SPI_SLAVE_RX_BYTE_COUNT_EN
      fw_q        <= fw_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef SPI_SLAVE_RX_BYTE_COUNT_EN
  assign frame_words = fw_q;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: one falling-edge and one rising-edge instance share the SPI pins;
// a word-level event model predicts delivery, overrun, frame_err and busy cycle by cycle.
module tb_spi_slave_rx;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n, sclk, cs, mosi, rx_ready;
  logic [DW-1:0] rx_data [2];
  logic rx_valid [2];
  logic overrun [2];
  logic frame_err [2];
  logic busy [2];
`ifdef SPI_SLAVE_RX_BYTE_COUNT_EN
  logic [7:0] fw [2];
`endif

  spi_slave_rx #(.DATA_W(DW), .SAMPLE_RISE(1'b0)) u_fall (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready),
    .overrun(overrun[0]), .frame_err(frame_err[0]),
`ifdef SPI_SLAVE_RX_BYTE_COUNT_EN
    .frame_words(fw[0]),
`endif
    .busy(busy[0]));

  spi_slave_rx #(.DATA_W(DW), .SAMPLE_RISE(1'b1)) u_rise (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready),
    .overrun(overrun[1]), .frame_err(frame_err[1]),
`ifdef SPI_SLAVE_RX_BYTE_COUNT_EN
    .frame_words(fw[1]),
`endif
    .busy(busy[1]));

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   cyc;
    int unsigned   dut;
    logic [DW-1:0] w;
  } ev_t;

  ev_t           wq[$];
  ev_t           fq[$];
  int unsigned   cyc;
  int            n_cmp, n_err;
  logic [DW-1:0] md [2];
  logic          mv [2];
  logic          csh [4];
  int            rdy_mode;
  int unsigned   pulse_cyc;
  int            bits, words;
  logic [DW-1:0] cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Ready driver: held low, held high, random, or a single pulse aimed at one cycle
  always @(negedge clk) begin
    case (rdy_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      2:       rx_ready = 1'($urandom_range(0, 1));
      default: rx_ready = (cyc + 1 == pulse_cyc);
    endcase
  end

  // Reference model: words arrive at their due cycle into a one-entry output slot
  always @(posedge clk) begin : model
    logic          rdy, arrived, eo, ef;
    logic [DW-1:0] w;
    rdy = rx_ready;
    cyc++;
    csh[cyc % 4] = cs;
    #1;
    if (!rst_n) begin
      wq.delete();
      fq.delete();
      for (int m = 0; m < 2; m++) begin
        mv[m] = 1'b0;
        md[m] = '0;
        check($sformatf("rst_valid%0d", m), rx_valid[m], 0);
      end
      for (int k = 0; k < 4; k++) csh[k] = 1'b1;
    end else begin
      for (int m = 0; m < 2; m++) begin
        arrived = 1'b0; eo = 1'b0; ef = 1'b0; w = '0;
        for (int i = 0; i < wq.size(); i++)
          if (wq[i].dut == m && wq[i].cyc == cyc) begin
            w = wq[i].w; wq.delete(i); arrived = 1'b1; break;
          end
        if (arrived) begin
          if (!mv[m] || rdy) begin md[m] = w; mv[m] = 1'b1; end
          else eo = 1'b1;
        end else if (mv[m] && rdy) begin
          mv[m] = 1'b0;
        end
        for (int i = 0; i < fq.size(); i++)
          if (fq[i].dut == m && fq[i].cyc == cyc) begin
            fq.delete(i); ef = 1'b1; break;
          end
        check($sformatf("rx_valid%0d", m), rx_valid[m], mv[m]);
        check($sformatf("rx_data%0d", m), rx_data[m], md[m]);
        check($sformatf("overrun%0d", m), overrun[m], eo);
        check($sformatf("frame_err%0d", m), frame_err[m], ef);
        check($sformatf("busy%0d", m), busy[m], !csh[(cyc + 2) % 4]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input int unsigned d, input logic [DW-1:0] w);
    ev_t e;
    e.cyc = cyc + 4; e.dut = d; e.w = w;
    wq.push_back(e);
    if (d == 0 && rdy_mode == 3) pulse_cyc = e.cyc;
  endtask

  task automatic send_bit(input logic b, input int p);
    logic [DW-1:0] nxt;
    logic          last, live;
    live = (cs === 1'b0);
    nxt  = {cur[DW-2:0], b};
    last = live && (bits == DW - 1);
    mosi = b;
    tick(2);
    sclk = 1'b1;
    if (last) push_word(1, nxt);
    tick(p);
    sclk = 1'b0;
    if (last) push_word(0, nxt);
    tick(2);
    if (live) begin
      cur  = nxt;
      bits = last ? 0 : bits + 1;
      if (last) words++;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int p);
    for (int i = DW - 1; i >= 0; i--) send_bit(w[i], p);
  endtask

  task automatic cs_fall;
    cs = 1'b0; bits = 0; words = 0; cur = '0;
    tick(4);
`ifdef SPI_SLAVE_RX_BYTE_COUNT_EN
    check("fw_clear0", fw[0], 0);
    check("fw_clear1", fw[1], 0);
`endif
  endtask

  task automatic cs_rise;
    ev_t e;
    if (bits != 0) begin
      e.cyc = cyc + 3; e.w = '0;
      e.dut = 0; fq.push_back(e);
      e.dut = 1; fq.push_back(e);
    end
    cs = 1'b1;
    tick(6);
`ifdef SPI_SLAVE_RX_BYTE_COUNT_EN
    check("fw_hold0", fw[0], (words > 255) ? 255 : words);
    check("fw_hold1", fw[1], (words > 255) ? 255 : words);
`endif
    bits = 0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s_valid%0d", tag, m), rx_valid[m], 0);
      check($sformatf("%s_data%0d", tag, m), rx_data[m], 0);
      check($sformatf("%s_ovr%0d", tag, m), overrun[m], 0);
      check($sformatf("%s_ferr%0d", tag, m), frame_err[m], 0);
      check($sformatf("%s_busy%0d", tag, m), busy[m], 0);
`ifdef SPI_SLAVE_RX_BYTE_COUNT_EN
      check($sformatf("%s_fw%0d", tag, m), fw[m], 0);
`endif
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; pulse_cyc = 0;
    rst_n = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; rx_ready = 1'b0;
    rdy_mode = 1; bits = 0; words = 0; cur = '0;
    for (int m = 0; m < 2; m++) begin md[m] = '0; mv[m] = 1'b0; end
    for (int k = 0; k < 4; k++) csh[k] = 1'b1;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // sclk activity with cs high must produce nothing
    for (int i = 0; i < DW + 3; i++) send_bit(1'($urandom_range(0, 1)), 3);

    cs_fall; send_word(8'hAA, 4); cs_rise;

    rdy_mode = 0;
    cs_fall; send_word(8'h3C, 4); send_word(8'hC3, 4); cs_rise;
    tick(3); rdy_mode = 1; tick(4);

    cs_fall; for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 3); cs_rise;
    cs_fall; send_word(8'h5A, 4); cs_rise;

    rdy_mode = 3;
    cs_fall; send_word(8'h11, 4); tick(2); send_word(8'h22, 4); cs_rise;
    rdy_mode = 1; tick(4);

    cs_fall; send_word(8'h01, 3); send_word(8'h02, 5); send_word(8'h03, 4); cs_rise;
    cs_fall; cs_rise;

    for (int f = 0; f < 30; f++) begin
      int nw, tb, p;
      rdy_mode = $urandom_range(0, 2);
      nw = $urandom_range(0, 3);
      tb = $urandom_range(0, DW - 1);
      cs_fall;
      for (int k = 0; k < nw; k++) begin
        p = $urandom_range(3, 6);
        send_word(DW'($urandom), p);
      end
      for (int k = 0; k < tb; k++) send_bit(1'($urandom_range(0, 1)), $urandom_range(3, 5));
      cs_rise;
      rdy_mode = 1; tick(3);
    end

    // Asynchronous reset in the middle of a word with a word pending
    rdy_mode = 0;
    cs_fall; send_word(DW'($urandom), 4);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 4);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    cs = 1'b1; sclk = 1'b0; bits = 0; words = 0;
    tick(3);
    rst_n = 1'b1;
    rdy_mode = 1;
    tick(3);
    cs_fall; send_word(8'hE7, 4); cs_rise;

    tick(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI target-side receiver; deserialises MOSI under CS/SCLK from an SPI initiator.
- All SPI inputs are oversampled in the system clock domain; no logic is clocked by sclk.
- Delivers each completed word on a valid/ready interface to downstream logic.
- Flags overruns and words truncated by CS deassertion.

Parameters:
DATA_W, 8, bits per word; MSB received first.
SAMPLE_RISE, 0, 0 = sample MOSI on SCLK falling edge; 1 = sample on rising edge.

Ports:
clk  input  1  system clock; all logic is clocked on its rising edge.
rst_n  input  1  reset, asynchronous and active-low.
sclk  input  1  SPI serial clock from the initiator; asynchronous to clk.
cs  input  1  chip select, active-low; asynchronous to clk.
mosi  input  1  serial data from the initiator.
rx_data  output  DATA_W  last completed word; held stable while rx_valid=1.
rx_valid  output  1  word available.
rx_ready  input  1  consumer accepts the word when rx_valid & rx_ready.
overrun  output  1  one-cycle pulse: a word completed while rx_valid=1; the new word is dropped.
frame_err  output  1  one-cycle pulse: cs rose with 1..DATA_W-1 bits shifted.
busy  output  1  high when state is SHIFT.

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0.
  - shift register=0, bit counter=0, state=IDLE.
  - Synchroniser flops: sclk and mosi stages=0, cs stages=1.
- Synchronisation:
  - sclk, cs and mosi each pass through a 2-flop synchroniser: sclk_s, cs_s, mosi_s.
  - A registered copy sclk_d yields the sample strobe: falling = sclk_d & ~sclk_s; rising = ~sclk_d & sclk_s; strobe selected by SAMPLE_RISE.
  - Each SCLK high and low phase must be >= 3 clk cycles; shorter phases are unsupported.
- State machine:
  - IDLE: shift register and bit counter held at 0. cs_s=0 -> SHIFT.
  - SHIFT, on strobe: shift_reg <= {shift_reg[DATA_W-2:0], mosi_s}; bit_cnt <= bit_cnt+1.
  - SHIFT, on the strobe capturing bit DATA_W-1 (bit_cnt==DATA_W-1): bit_cnt <= 0; word complete; stay in SHIFT, so multiple words per CS frame are supported.
  - SHIFT, cs_s=1: -> IDLE. If bit_cnt != 0, pulse frame_err for one cycle and discard the partial word.
- Word delivery:
  - On word complete with rx_valid=0: on the next clk edge, rx_data <= the full shifted word and rx_valid <= 1.
  - Latency from the sampling SCLK edge at the pin to rx_valid: 4 clk cycles (2 synchroniser + 1 edge detect + 1 output register).
  - On word complete with rx_valid=1 and rx_ready=0: rx_data unchanged; pulse overrun.
  - Completion in the same cycle as a handshake (rx_valid & rx_ready): counts as a free slot; load the new word and keep rx_valid=1; no overrun.
  - rx_valid clears on handshake when no word completes in that cycle.
- Boundary cases:
  - Strobe and cs_s rising in the same cycle: cs wins; the sample is ignored.
  - bit_cnt is width clog2(DATA_W), reset to 0 at every transition into SHIFT.
  - rst_n asserted mid-word: everything returns to reset values immediately; no frame_err.
  - rx_ready is ignored while rx_valid=0.

Optional Feature:
SPI_SLAVE_RX_BYTE_COUNT_EN
- Defined:
  - Adds output frame_words[7:0].
  - Cleared on each IDLE->SHIFT transition.
  - Incremented on each word complete, including overrun-dropped words; saturates at 255.
  - Holds its value after cs rises until the next frame.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n low asynchronously mid-clock -> all outputs 0 without waiting for a clk edge; cs high, sclk toggling -> rx_valid stays 0.
- Single word, SAMPLE_RISE=0: cs low, 8 falling SCLK edges carrying 1,0,1,0,1,0,1,0 (phases 4 clk), rx_ready=1 -> rx_data=8'hAA and rx_valid high exactly 4 clk after the 8th falling edge; one-cycle pulse; frame_err=0.
- Back-to-back words, rx_ready=0: bytes 8'h3C then 8'hC3 in one CS frame -> rx_data=8'h3C held, overrun pulses once at the second completion; raise rx_ready -> handshake, rx_valid drops.
- Truncated frame: cs low, 5 bits, cs high -> frame_err one pulse, no rx_valid. Next full frame of 8'h5A -> rx_data=8'h5A, proving no stale bits.
- Simultaneous completion and handshake: rx_valid=1 with 8'h11, rx_ready=1 in the cycle 8'h22 completes -> rx_data=8'h22, rx_valid stays 1, overrun=0.
- Rising-edge mode and macro: SAMPLE_RISE=1 with the macro defined, 3 words 8'h01, 8'h02, 8'h03 -> captured correctly; frame_words=3 after cs rises; frame_words=0 after the next cs fall.
